expr_eval_ctrl: RTL and testbench

- Stream controller for the digit/operator expression format "d(op d)*", where d is an ASCII digit '0'-'9' and op is '+' or '*'.
- Accepts one ASCII character per cycle over a valid/ready handshake.
- Checks the frame syntax and evaluates it with the usual precedence ('*' binds tighter than '+').
- On the terminator '=' (8'h3D), presents the result and a syntax-ok flag on a second valid/ready handshake. It sits between the character source and downstream result consumers.

---
 rtl/expr_eval_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_expr_eval_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/expr_eval_ctrl.sv
// ---------------------------------------------------------------------------
// expr_eval_ctrl
//
// Streaming evaluator for frames of the form  d(op d)* '='  where d is a
// single ASCII digit and op is '+' or '*'. Characters arrive one per cycle
// over a valid/ready handshake. The frame is syntax-checked and evaluated
// on the fly with '*' binding tighter than '+'. On '=' the result and a
// syntax-ok flag are held on a second valid/ready handshake until taken.
//
// Evaluation keeps a running sum of completed additive terms (sum_reg) and
// the product currently being built (term_reg). mul_pend_reg remembers that
// the next digit multiplies into term_reg instead of starting a new term.
//
// Parameters
//   W        width of result / arithmetic registers (all math modulo 2^W)
//   MAX_LEN  max accepted non-'=' characters per frame (>= 1)
//
// Ports
//   clk        clock, rising edge
//   clr_n      asynchronous active-low reset
//   in_valid   in_data carries a character this cycle
//   in_data    ASCII character
//   in_ready   controller accepts a character this cycle
//   res_valid  result available
//   res_ready  consumer takes the result this cycle
//   res_ok     1 = frame syntactically valid, 0 = error
//   res_value  evaluated value (0 when res_ok = 0)
// ---------------------------------------------------------------------------
module expr_eval_ctrl #(
    parameter int W       = 16,
    parameter int MAX_LEN = 31
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    output logic         in_ready,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         res_ok,
    output logic [W-1:0] res_value
);

    localparam int LW = $clog2(MAX_LEN + 1);

    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MUL   = 8'h2A;
    localparam logic [7:0] CH_EQ    = 8'h3D;

    typedef enum logic [1:0] {
        EXP_NUM = 2'd0,
        EXP_OP  = 2'd1,
        ERR     = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t          state_reg;
    logic [W-1:0]    sum_reg;
    logic [W-1:0]    term_reg;
    logic            mul_pend_reg;
    logic [LW-1:0]   len_reg;
    logic            in_ready_reg;
    logic            res_valid_reg;
    logic            res_ok_reg;
    logic [W-1:0]    res_value_reg;

    // ------------------------------------------------------------------
    // Character decode and arithmetic datapath
    // ------------------------------------------------------------------
    logic            accept;
    logic            is_digit;
    logic            is_plus;
    logic            is_mul;
    logic            is_eq;
    logic            len_full;
    logic [7:0]      digit_code;
    logic [W-1:0]    digit_val;
    logic [W-1:0]    prod;
    logic [W-1:0]    sum_term;

    assign accept     = in_valid && in_ready_reg;
    assign is_digit   = (in_data >= CH_0) && (in_data <= CH_9);
    assign is_plus    = (in_data == CH_PLUS);
    assign is_mul     = (in_data == CH_MUL);
    assign is_eq      = (in_data == CH_EQ);
    assign len_full   = (len_reg == LW'(MAX_LEN));

    // Digit value is only used when is_digit, so the subtraction never
    // needs to handle codes below '0'.
    assign digit_code = in_data - CH_0;
    assign digit_val  = W'(digit_code);

    // Both results are truncated to W bits by the assignment width,
    // giving the required wrap-around behaviour at every step.
    assign prod       = term_reg * digit_val;
    assign sum_term   = sum_reg + term_reg;

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_reg     <= EXP_NUM;
            sum_reg       <= '0;
            term_reg      <= '0;
            mul_pend_reg  <= 1'b0;
            len_reg       <= '0;
            in_ready_reg  <= 1'b1;
            res_valid_reg <= 1'b0;
            res_ok_reg    <= 1'b0;
            res_value_reg <= '0;
        end else begin
            case (state_reg)
                DONE: begin
                    // Result handshake; the frame state is wiped so the
                    // next frame starts from a clean accumulator.
                    if (res_ready) begin
                        state_reg     <= EXP_NUM;
                        sum_reg       <= '0;
                        term_reg      <= '0;
                        mul_pend_reg  <= 1'b0;
                        len_reg       <= '0;
                        in_ready_reg  <= 1'b1;
                        res_valid_reg <= 1'b0;
                    end
                end

                default: begin
                    if (accept) begin
                        if (is_eq) begin
                            // Terminator: only a frame ending right after a
                            // digit is valid. Every other path reports 0.
                            state_reg     <= DONE;
                            in_ready_reg  <= 1'b0;
                            res_valid_reg <= 1'b1;
                            if (state_reg == EXP_OP) begin
                                res_ok_reg    <= 1'b1;
                                res_value_reg <= sum_term;
                            end else begin
                                res_ok_reg    <= 1'b0;
                                res_value_reg <= '0;
                            end
                        end else if (len_full) begin
                            // Frame too long; len stays saturated.
                            state_reg <= ERR;
                        end else begin
                            len_reg <= len_reg + LW'(1);
                            case (state_reg)
                                EXP_NUM: begin
                                    if (is_digit) begin
                                        term_reg  <= mul_pend_reg ? prod : digit_val;
                                        state_reg <= EXP_OP;
                                    end else begin
                                        state_reg <= ERR;
                                    end
                                end
                                EXP_OP: begin
                                    if (is_plus) begin
                                        sum_reg      <= sum_term;
                                        mul_pend_reg <= 1'b0;
                                        state_reg    <= EXP_NUM;
                                    end else if (is_mul) begin
                                        mul_pend_reg <= 1'b1;
                                        state_reg    <= EXP_NUM;
                                    end else begin
                                        // A second digit (multi-digit
                                        // number) is a syntax error too.
                                        state_reg <= ERR;
                                    end
                                end
                                default: begin
                                    // ERR: discard until '='.
                                    state_reg <= ERR;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign res_valid = res_valid_reg;
    assign res_ok    = res_ok_reg;
    assign res_value = res_value_reg;

endmodule

// File: tb/tb_expr_eval_ctrl.sv
// ---------------------------------------------------------------------------
// tb_expr_eval_ctrl
//
// Drives two instances (W=8 and W=16, MAX_LEN=31) with identical character
// streams. Expected results are queued when a frame is driven and popped
// when the result handshake appears.
// ---------------------------------------------------------------------------
module tb_expr_eval_ctrl;

    logic        clk;
    logic        clr_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        res_ready;

    logic        in_ready8,  res_valid8,  res_ok8;
    logic [7:0]  res_value8;
    logic        in_ready16, res_valid16, res_ok16;
    logic [15:0] res_value16;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic        ok;
        logic [31:0] v8;
        logic [31:0] v16;
    } exp_t;

    exp_t sb[$];

    expr_eval_ctrl #(.W(8), .MAX_LEN(31)) u8 (
        .clk       (clk),
        .clr_n     (clr_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready8),
        .res_valid (res_valid8),
        .res_ready (res_ready),
        .res_ok    (res_ok8),
        .res_value (res_value8)
    );

    expr_eval_ctrl #(.W(16), .MAX_LEN(31)) u16 (
        .clk       (clk),
        .clr_n     (clr_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready16),
        .res_valid (res_valid16),
        .res_ready (res_ready),
        .res_ok    (res_ok16),
        .res_value (res_value16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Present one character and hold it until accepted (bounded).
    task automatic send_char(input logic [7:0] c);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = c;
        while (!in_ready8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready8) begin
            check("in_ready_timeout", 32'(in_ready8), 1);
        end else begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for a result, pop the scoreboard and compare.
    task automatic collect(input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (!res_valid8 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!res_valid8) begin
            check({tag, "_res_valid_timeout"}, 32'(res_valid8), 1);
        end else if (sb.size() == 0) begin
            check({tag, "_unexpected_result"}, 32'(res_valid8), 0);
        end else begin
            e = sb.pop_front();
            check({tag, "_ok8"},     32'(res_ok8),     32'(e.ok));
            check({tag, "_value8"},  32'(res_value8),  e.v8);
            check({tag, "_valid16"}, 32'(res_valid16), 1);
            check({tag, "_ok16"},    32'(res_ok16),    32'(e.ok));
            check({tag, "_value16"}, 32'(res_value16), e.v16);
        end
    endtask

    // Drive a full frame ending in '='; check latency, result, and (when
    // res_ready is high) the handshake release.
    task automatic send_frame(input string s, input logic ok,
                              input logic [31:0] v8, input logic [31:0] v16);
        exp_t e;
        e.ok = ok; e.v8 = v8; e.v16 = v16;
        sb.push_back(e);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
        check({s, "_latency"}, 32'(res_valid8), 1);
        collect(s);
        if (res_ready) begin
            @(posedge clk);
            #1;
            check({s, "_released_valid"}, 32'(res_valid8), 0);
            check({s, "_released_ready"}, 32'(in_ready8), 1);
        end
    endtask

    initial begin
        string s;
        logic  seen;

        clr_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        res_ready = 1'b0;

        // Reset state
        #12;
        check("rst_valid", 32'(res_valid8), 0);
        check("rst_ok",    32'(res_ok8),    0);
        check("rst_value", 32'(res_value8), 0);
        check("rst_ready", 32'(in_ready8),  1);
        @(negedge clk);
        clr_n = 1'b1;

        // Precedence
        res_ready = 1'b1;
        send_frame("3+4*5=",   1'b1, 23, 23);
        send_frame("2*3*4+1=", 1'b1, 25, 25);

        // Syntax errors, then recovery
        send_frame("3++4=", 1'b0, 0, 0);
        send_frame("12=",   1'b0, 0, 0);
        send_frame("=",     1'b0, 0, 0);
        send_frame("5+=",   1'b0, 0, 0);
        send_frame("7a=",   1'b0, 0, 0);
        send_frame("8=",    1'b1, 8, 8);

        // Wrap-around: 9^5 = 59049 -> 169 mod 256
        send_frame("9*9*9*9*9=", 1'b1, 169, 59049);

        // Unterminated frame: no result ever appears
        s = "9*9*9+99";
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            seen = seen | res_valid8;
        end
        check("no_term_valid", 32'(seen), 0);
        send_frame("=", 1'b0, 0, 0);

        // Length limit: 31 characters ok, 33 characters error
        s = "1";
        for (int k = 0; k < 15; k++) s = {s, "+1"};
        send_frame({s, "="}, 1'b1, 16, 16);
        s = {s, "+1"};
        send_frame({s, "="}, 1'b0, 0, 0);

        // Backpressure: result held, nothing accepted
        res_ready = 1'b0;
        send_frame("6*7=", 1'b1, 42, 42);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = "1";
            check("bp_valid", 32'(res_valid8), 1);
            check("bp_ready", 32'(in_ready8),  0);
            check("bp_value", 32'(res_value8), 42);
        end
        @(negedge clk);
        res_ready = 1'b1;
        in_data   = "=";
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_release_valid", 32'(res_valid8), 0);
        check("bp_release_ready", 32'(in_ready8),  1);
        send_frame("5=", 1'b1, 5, 5);

        // Asynchronous reset mid-frame
        s = "4*5+";
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
        #2;
        clr_n = 1'b0;
        #1;
        check("arst_mid_valid", 32'(res_valid8),  0);
        check("arst_mid_ok",    32'(res_ok8),     0);
        check("arst_mid_value", 32'(res_value8),  0);
        check("arst_mid_ready", 32'(in_ready8),   1);
        check("arst_mid_v16",   32'(res_value16), 0);
        @(negedge clk);
        clr_n = 1'b1;

        // Asynchronous reset while holding a result
        res_ready = 1'b0;
        send_frame("4*5=", 1'b1, 20, 20);
        #2;
        clr_n = 1'b0;
        #1;
        check("arst_done_valid", 32'(res_valid8), 0);
        check("arst_done_ok",    32'(res_ok8),    0);
        check("arst_done_value", 32'(res_value8), 0);
        check("arst_done_ready", 32'(in_ready8),  1);
        @(negedge clk);
        clr_n     = 1'b1;
        res_ready = 1'b1;
        send_frame("2+2=", 1'b1, 4, 4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
